// File: rtl/rename_unit_nw_pkg.sv
// rename_pkg: default sizes, tag widths and tag types
// shared by the rename unit, its free list and its interface.
package rename_pkg;
  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int REN_W_DEF = 2;
  localparam int RET_W_DEF = 2;
  localparam int PW = $clog2(PHYS_REGS_DEF);
  localparam int AW = $clog2(ARCH_REGS_DEF);

  typedef logic [PW-1:0] preg_t;
  typedef logic [AW-1:0] areg_t;
endpackage

// File: rtl/rename_unit_nw_if.sv
// rename_unit_nw_if: rename group, renamed results,
// retire slots, flush and free-tag count.
interface rename_unit_nw_if #(
  parameter int REN_W = rename_pkg::REN_W_DEF,
  parameter int RET_W = rename_pkg::RET_W_DEF
);
  import rename_pkg::*;

  logic [REN_W-1:0] ren_valid;
  areg_t [REN_W-1:0] ren_rs1;
  areg_t [REN_W-1:0] ren_rs2;
  areg_t [REN_W-1:0] ren_rd;
  logic [REN_W-1:0] ren_we;
  logic ren_ready;

  logic [REN_W-1:0] out_valid;
  preg_t [REN_W-1:0] out_prs1;
  preg_t [REN_W-1:0] out_prs2;
  preg_t [REN_W-1:0] out_prd;
  preg_t [REN_W-1:0] out_old_prd;

  logic [RET_W-1:0] ret_valid;
  areg_t [RET_W-1:0] ret_rd;
  preg_t [RET_W-1:0] ret_prd;
  preg_t [RET_W-1:0] ret_old_prd;

  logic flush;
  logic [PW:0] free_count;

  modport master (
    output ren_valid, ren_rs1, ren_rs2,
    output ren_rd, ren_we,
    input  ren_ready,
    input  out_valid, out_prs1, out_prs2,
    input  out_prd, out_old_prd,
    output ret_valid, ret_rd,
    output ret_prd, ret_old_prd,
    output flush,
    input  free_count
  );

  modport slave (
    input  ren_valid, ren_rs1, ren_rs2,
    input  ren_rd, ren_we,
    output ren_ready,
    output out_valid, out_prs1, out_prs2,
    output out_prd, out_old_prd,
    input  ret_valid, ret_rd,
    input  ret_prd, ret_old_prd,
    input  flush,
    output free_count
  );
endinterface

// File: rtl/rename_unit_nw_free_list_alloc.sv
// free_list_alloc: free tag vector, lowest-free select per slot,
// retire return and flush rebuild from committed tags.
module free_list_alloc #(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS_DEF,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS_DEF,
  parameter int REN_W = rename_pkg::REN_W_DEF,
  parameter int RET_W = rename_pkg::RET_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic [REN_W-1:0] req_i,
  input  logic accept_i,
  input  logic [RET_W-1:0] ret_valid_i,
  input  rename_pkg::preg_t [RET_W-1:0] ret_old_prd_i,
  input  logic flush_i,
  input  logic [PHYS_REGS-1:0] cmt_use_i,
  output rename_pkg::preg_t [REN_W-1:0] tag_o,
  output logic [rename_pkg::PW:0] free_count_o
);
  import rename_pkg::*;

  localparam logic [PHYS_REGS-1:0] FREE_RST =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PHYS_REGS-1:0] free_q;
  logic [PHYS_REGS-1:0] free_d;
  logic [PHYS_REGS-1:0] avail;
  logic [PHYS_REGS-1:0] taken;
  logic [PHYS_REGS-1:0] freed;
  logic hit;

  assign free_count_o = (PW+1)'($countones(free_q));

  // Each slot takes the lowest tag left over by older slots.
  always_comb begin
    avail = free_q;
    taken = '0;
    hit = 1'b0;
    for (int s = 0; s < REN_W; s++) begin
      tag_o[s] = '0;
      hit = 1'b0;
      for (int p = PHYS_REGS-1; p > 0; p--) begin
        if (req_i[s] && avail[p]) begin
          tag_o[s] = preg_t'(p);
          hit = 1'b1;
        end
      end
      if (hit) begin
        avail[tag_o[s]] = 1'b0;
        taken[tag_o[s]] = 1'b1;
      end
    end
  end

  // Next free vector; P0 can never become free.
  always_comb begin
    freed = '0;
    for (int k = 0; k < RET_W; k++) begin
      if (ret_valid_i[k] && ret_old_prd_i[k] != '0)
        freed[ret_old_prd_i[k]] = 1'b1;
    end
    if (flush_i)
      free_d = ~cmt_use_i;
    else if (accept_i)
      free_d = (free_q & ~taken) | freed;
    else
      free_d = free_q | freed;
    free_d[0] = 1'b0;
  end

  // Free vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      free_q <= FREE_RST;
    else
      free_q <= free_d;
  end
endmodule

// File: rtl/rename_unit_nw.sv
// rename_unit_nw: multi-wide register rename with speculative
// and committed RATs, intra-group bypass and flush recovery.
module rename_unit_nw #(
  parameter int ARCH_REGS = rename_pkg::ARCH_REGS_DEF,
  parameter int PHYS_REGS = rename_pkg::PHYS_REGS_DEF,
  parameter int REN_W = rename_pkg::REN_W_DEF,
  parameter int RET_W = rename_pkg::RET_W_DEF
) (
  input logic clk,
  input logic rst,
  rename_unit_nw_if.slave io
);
  import rename_pkg::*;

  preg_t spec_q [ARCH_REGS];
  preg_t spec_d [ARCH_REGS];
  preg_t cmt_q [ARCH_REGS];
  preg_t cmt_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] cmt_use;

  logic [REN_W-1:0] alloc_req;
  preg_t [REN_W-1:0] alloc_tag;
  logic [PW:0] free_count;
  logic ren_ready;
  logic accept;

  preg_t [REN_W-1:0] prs1, prs2, prd, oprd;
  logic [REN_W-1:0] out_valid_q;
  preg_t [REN_W-1:0] out_prs1_q, out_prs2_q;
  preg_t [REN_W-1:0] out_prd_q, out_old_q;

  assign ren_ready = (free_count >= (PW+1)'(REN_W)) && !io.flush;
  assign accept = (|io.ren_valid) && ren_ready;

  assign io.ren_ready = ren_ready;
  assign io.free_count = free_count;
  assign io.out_valid = out_valid_q;
  assign io.out_prs1 = out_prs1_q;
  assign io.out_prs2 = out_prs2_q;
  assign io.out_prd = out_prd_q;
  assign io.out_old_prd = out_old_q;

  free_list_alloc #(
    .ARCH_REGS(ARCH_REGS),
    .PHYS_REGS(PHYS_REGS),
    .REN_W(REN_W),
    .RET_W(RET_W)
  ) u_free (
    .clk(clk),
    .rst(rst),
    .req_i(alloc_req),
    .accept_i(accept),
    .ret_valid_i(io.ret_valid),
    .ret_old_prd_i(io.ret_old_prd),
    .flush_i(io.flush),
    .cmt_use_i(cmt_use),
    .tag_o(alloc_tag),
    .free_count_o(free_count)
  );

  // Lookups, with older slots in the group overriding the RAT.
  always_comb begin
    for (int s = 0; s < REN_W; s++) begin
      alloc_req[s] = io.ren_valid[s] && io.ren_we[s]
                     && (io.ren_rd[s] != '0);
    end
    for (int s = 0; s < REN_W; s++) begin
      prs1[s] = spec_q[io.ren_rs1[s]];
      prs2[s] = spec_q[io.ren_rs2[s]];
      oprd[s] = spec_q[io.ren_rd[s]];
      for (int j = 0; j < REN_W; j++) begin
        if (j < s && alloc_req[j]) begin
          if (io.ren_rd[j] == io.ren_rs1[s])
            prs1[s] = alloc_tag[j];
          if (io.ren_rd[j] == io.ren_rs2[s])
            prs2[s] = alloc_tag[j];
          if (io.ren_rd[j] == io.ren_rd[s])
            oprd[s] = alloc_tag[j];
        end
      end
      if (io.ren_rs1[s] == '0) prs1[s] = '0;
      if (io.ren_rs2[s] == '0) prs2[s] = '0;
      prd[s] = alloc_req[s] ? alloc_tag[s] : '0;
      if (!alloc_req[s]) oprd[s] = '0;
    end
  end

  // RAT next state; flush restores from committed incl. retires.
  always_comb begin
    cmt_d = cmt_q;
    for (int k = 0; k < RET_W; k++) begin
      if (io.ret_valid[k] && io.ret_rd[k] != '0)
        cmt_d[io.ret_rd[k]] = io.ret_prd[k];
    end
    spec_d = spec_q;
    if (io.flush) begin
      spec_d = cmt_d;
    end else if (accept) begin
      for (int s = 0; s < REN_W; s++) begin
        if (alloc_req[s])
          spec_d[io.ren_rd[s]] = alloc_tag[s];
      end
    end
    cmt_use = '0;
    for (int a = 0; a < ARCH_REGS; a++)
      cmt_use[cmt_d[a]] = 1'b1;
  end

  // RAT state and registered results; reset drops pending group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_q[i] <= preg_t'(i);
        cmt_q[i] <= preg_t'(i);
      end
      out_valid_q <= '0;
      out_prs1_q <= '0;
      out_prs2_q <= '0;
      out_prd_q <= '0;
      out_old_q <= '0;
    end else begin
      spec_q <= spec_d;
      cmt_q <= cmt_d;
      out_valid_q <= accept ? io.ren_valid : '0;
      out_prs1_q <= accept ? prs1 : '0;
      out_prs2_q <= accept ? prs2 : '0;
      out_prd_q <= accept ? prd : '0;
      out_old_q <= accept ? oprd : '0;
    end
  end
endmodule

// File: tb/tb_rename_unit_nw.sv
// tb_rename_unit_nw: directed and random rename traffic, checked
// by a scoreboard fed from a sequential-rename reference model.
module tb_rename_unit_nw;
  import rename_pkg::*;

  localparam int RW = 2;
  localparam int TW = 2;
  localparam int NA = 32;
  localparam int NP = 64;

  typedef struct packed {
    logic [RW-1:0] v;
    preg_t [RW-1:0] s1;
    preg_t [RW-1:0] s2;
    preg_t [RW-1:0] d;
    preg_t [RW-1:0] od;
  } exp_t;

  typedef struct {
    int rd;
    int prd;
    int old;
  } inst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  inst_t infl[$];
  int m_spec[NA];
  int m_cmt[NA];
  bit m_free[NP];
  int m_cnt;
  bit use_dir = 1'b0;
  exp_t dir_exp;

  always #5 clk = ~clk;

  rename_unit_nw_if #(.REN_W(RW), .RET_W(TW)) bus ();

  rename_unit_nw dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic idle();
    bus.ren_valid = '0;
    bus.ren_we = '0;
    bus.ren_rs1 = '0;
    bus.ren_rs2 = '0;
    bus.ren_rd = '0;
    bus.ret_valid = '0;
    bus.ret_rd = '0;
    bus.ret_prd = '0;
    bus.ret_old_prd = '0;
    bus.flush = 1'b0;
  endtask

  task automatic ren(input int s, input int we, input int rd,
                     input int r1, input int r2);
    bus.ren_valid[s] = 1'b1;
    bus.ren_we[s] = (we != 0);
    bus.ren_rd[s] = areg_t'(rd);
    bus.ren_rs1[s] = areg_t'(r1);
    bus.ren_rs2[s] = areg_t'(r2);
  endtask

  task automatic ret(input int k, input int rd, input int prd,
                     input int old);
    bus.ret_valid[k] = 1'b1;
    bus.ret_rd[k] = areg_t'(rd);
    bus.ret_prd[k] = preg_t'(prd);
    bus.ret_old_prd[k] = preg_t'(old);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NA; i++) begin
      m_spec[i] = i;
      m_cmt[i] = i;
    end
    for (int p = 0; p < NP; p++) m_free[p] = (p >= NA);
    m_cnt = NP - NA;
    sb.delete();
    infl.delete();
  endfunction

  // One cycle of the reference model: slots renamed in program
  // order against a live map, then retires, then flush recovery.
  task automatic step();
    bit rdy;
    int r1, r2, rd, t;
    int fr[$];
    exp_t e;
    #1;
    rdy = (m_cnt >= RW) && !bus.flush;
    chk("ren_ready", 64'(bus.ren_ready), 64'(rdy));
    chk("free_count", 64'(bus.free_count), 64'(m_cnt));
    if (bus.ren_valid != '0 && rdy) begin
      e = '0;
      e.v = bus.ren_valid;
      for (int s = 0; s < RW; s++) begin
        r1 = int'(bus.ren_rs1[s]);
        r2 = int'(bus.ren_rs2[s]);
        rd = int'(bus.ren_rd[s]);
        e.s1[s] = preg_t'((r1 == 0) ? 0 : m_spec[r1]);
        e.s2[s] = preg_t'((r2 == 0) ? 0 : m_spec[r2]);
        if (bus.ren_valid[s] && bus.ren_we[s] && rd != 0) begin
          t = 1;
          while (t < NP && !m_free[t]) t++;
          m_free[t] = 1'b0;
          e.d[s] = preg_t'(t);
          e.od[s] = preg_t'(m_spec[rd]);
          infl.push_back('{rd: rd, prd: t, old: m_spec[rd]});
          m_spec[rd] = t;
        end
      end
      sb.push_back(use_dir ? dir_exp : e);
    end
    for (int k = 0; k < TW; k++) begin
      if (bus.ret_valid[k]) begin
        if (bus.ret_rd[k] != '0)
          m_cmt[bus.ret_rd[k]] = int'(bus.ret_prd[k]);
        if (bus.ret_old_prd[k] != '0)
          fr.push_back(int'(bus.ret_old_prd[k]));
      end
    end
    if (bus.flush) begin
      m_spec = m_cmt;
      for (int p = 0; p < NP; p++) m_free[p] = (p != 0);
      for (int a = 0; a < NA; a++) m_free[m_cmt[a]] = 1'b0;
      infl.delete();
    end else begin
      foreach (fr[i]) m_free[fr[i]] = 1'b1;
    end
    m_cnt = 0;
    for (int p = 0; p < NP; p++) m_cnt += int'(m_free[p]);
  endtask

  task automatic dstep(input exp_t x);
    dir_exp = x;
    use_dir = 1'b1;
    step();
    use_dir = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_prd", 64'(bus.out_prd), 64'(0));
    chk("rst_out_old", 64'(bus.out_old_prd), 64'(0));
    chk("rst_free_count", 64'(bus.free_count), 64'(32));
    chk("rst_ready", 64'(bus.ren_ready), 64'(1));
    rst = 1'b0;
  endtask

  // Monitor: every presented group is matched against the queue.
  initial begin
    exp_t a;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid != '0) begin
        a.v = bus.out_valid;
        a.s1 = bus.out_prs1;
        a.s2 = bus.out_prs2;
        a.d = bus.out_prd;
        a.od = bus.out_old_prd;
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(a.v), 64'(0));
        end else begin
          x = sb.pop_front();
          chk("rename_out", 64'(a), 64'(x));
        end
      end
    end
  end

  initial begin
    exp_t x;
    inst_t it;
    bit go;
    idle();
    m_reset();
    do_reset();

    // two fresh destinations
    cyc(); ren(0, 1, 1, 0, 0); ren(1, 1, 2, 0, 0);
    x = '0; x.v = 2'b11;
    x.d[0] = 6'd32; x.od[0] = 6'd1;
    x.d[1] = 6'd33; x.od[1] = 6'd2;
    dstep(x);
    cyc(); step();
    chk("cnt_two_alloc", 64'(bus.free_count), 64'(30));

    // same rd twice with a dependent source
    do_reset();
    cyc(); ren(0, 1, 5, 0, 0); ren(1, 1, 5, 5, 0);
    x = '0; x.v = 2'b11;
    x.d[0] = 6'd32; x.od[0] = 6'd5;
    x.s1[1] = 6'd32; x.d[1] = 6'd33; x.od[1] = 6'd32;
    dstep(x);
    cyc(); ren(0, 0, 0, 5, 0);
    x = '0; x.v = 2'b01; x.s1[0] = 6'd33;
    dstep(x);

    // x0 destination and sources
    cyc(); ren(0, 1, 0, 0, 0); ren(1, 0, 7, 0, 3);
    x = '0; x.v = 2'b11; x.s2[1] = 6'd3;
    dstep(x);
    cyc(); step();
    chk("cnt_x0", 64'(bus.free_count), 64'(30));

    // flush with nothing retired
    do_reset();
    cyc(); ren(0, 1, 3, 0, 0);
    x = '0; x.v = 2'b01; x.d[0] = 6'd32; x.od[0] = 6'd3;
    dstep(x);
    cyc(); bus.flush = 1'b1; ren(0, 1, 9, 0, 0); step();
    cyc(); step();
    chk("flush_drop", 64'(bus.out_valid), 64'(0));
    chk("cnt_flush", 64'(bus.free_count), 64'(32));
    cyc(); ren(0, 1, 3, 3, 0);
    x = '0; x.v = 2'b01; x.s1[0] = 6'd3;
    x.d[0] = 6'd32; x.od[0] = 6'd3;
    dstep(x);

    // retire in the flush cycle
    do_reset();
    cyc(); bus.flush = 1'b1; ret(0, 4, 40, 4); step();
    cyc(); step();
    chk("cnt_flush_ret", 64'(bus.free_count), 64'(32));
    cyc(); ren(0, 1, 6, 4, 0); ren(1, 1, 7, 0, 0);
    x = '0; x.v = 2'b11; x.s1[0] = 6'd40;
    x.d[0] = 6'd4; x.od[0] = 6'd6;
    x.d[1] = 6'd32; x.od[1] = 6'd7;
    dstep(x);

    // exhaust the free list, then refill by retire
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(); ren(0, 1, 1, 0, 0); ren(1, 1, 2, 0, 0); step();
    end
    cyc(); ren(0, 1, 3, 0, 0); step();
    chk("empty_ready", 64'(bus.ren_ready), 64'(0));
    cyc(); ret(0, 5, 32, 5); step();
    cyc(); ret(0, 6, 33, 6); step();
    chk("one_free_ready", 64'(bus.ren_ready), 64'(0));
    chk("one_free_cnt", 64'(bus.free_count), 64'(1));
    cyc(); step();
    chk("two_free_ready", 64'(bus.ren_ready), 64'(1));

    // random traffic with in-order retires and rare flushes
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cyc();
      for (int s = 0; s < RW; s++) begin
        if ($urandom_range(3) != 0)
          ren(s, int'($urandom_range(1)), int'($urandom_range(9)),
              int'($urandom_range(9)), int'($urandom_range(9)));
      end
      go = 1'b1;
      for (int k = 0; k < TW; k++) begin
        if (go && infl.size() > 0 && $urandom_range(1) == 1) begin
          it = infl.pop_front();
          ret(k, it.rd, it.prd, it.old);
        end else begin
          go = 1'b0;
        end
      end
      if ($urandom_range(39) == 0) bus.flush = 1'b1;
      step();
      if (n == 300) begin
        @(posedge clk);
        #1;
        do_reset();
      end
    end

    repeat (3) begin
      cyc();
      step();
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_unit_nw.md
RENAME_UNIT_NW -- requirements
Module: rename_unit_nw

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ARCH_REGS, 32, architectural registers; x0 hardwired.
  PHYS_REGS, 64, physical registers; P0 reserved for x0.
  REN_W, 2, rename slots per cycle.
  RET_W, 2, retire slots per cycle.
  PW, $clog2(PHYS_REGS), physical tag width; AW = $clog2(ARCH_REGS).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock.
  rst  in  1  reset, asynchronous, active-high.
  ren_valid  in  REN_W  per-slot instruction valid; slot 0 is oldest.
  ren_rs1, ren_rs2, ren_rd  in  REN_W*AW  architectural sources and destination.
  ren_we  in  REN_W  slot writes rd.
  ren_ready  out  1  group accepted this cycle.
  out_valid  out  REN_W  renamed slot valid (registered).
  out_prs1, out_prs2, out_prd, out_old_prd  out  REN_W*PW  renamed tags; old_prd is the prior mapping of rd.
  ret_valid  in  RET_W  retire slot valid.
  ret_rd  in  RET_W*AW  retiring architectural rd.
  ret_prd, ret_old_prd  in  RET_W*PW  committed new tag and tag to free.
  flush  in  1  mispredict recovery.
  free_count  out  PW+1  current free tags.

Function
REQ-003 A group SHALL be accepted when any ren_valid bit is set, ren_ready=1 and flush=0; acceptance is all-or-nothing.
REQ-004 ren_ready SHALL equal (free_count >= REN_W) && !flush, using the registered count.
REQ-005 An allocating slot (valid, we, rd!=0) SHALL take the lowest-numbered free tag not taken by an older slot in the same group.
REQ-006 Renamed outputs SHALL appear one cycle after acceptance; out_valid SHALL be 0 in cycles with no accepted group.
REQ-007 A source equal to 0 SHALL map to P0. Otherwise the source SHALL take the prd of the youngest older slot in the group writing that register; if none, it SHALL take the RAT entry.
REQ-008 out_old_prd SHALL follow the same bypass rule for rd. Non-allocating slots SHALL output prd=0 and old_prd=0.
REQ-009 If two slots write the same rd, the speculative RAT SHALL end with the younger slot's tag.
REQ-010 On retire, the committed RAT[ret_rd] SHALL become ret_prd, and ret_old_prd SHALL return to the free list next cycle. A freed tag SHALL NOT be allocated in its free cycle. ret_old_prd=0 SHALL be ignored.
REQ-011 free_count next SHALL equal free_count - allocated + freed, and SHALL never exceed PHYS_REGS-1.
REQ-012 On flush, the speculative RAT SHALL load the committed RAT, including same-cycle retires. The free vector SHALL become the complement of committed-in-use tags. out_valid SHALL be 0 next cycle. Any rename group in that cycle SHALL be dropped.
REQ-013 Retire while the free list is empty SHALL unblock ren_ready next cycle.

Reset
REQ-014 On rst, both RATs SHALL hold entry i = i, and tags ARCH_REGS..PHYS_REGS-1 SHALL be free.
REQ-015 After reset, free_count SHALL be PHYS_REGS-ARCH_REGS, all out_* SHALL be 0, and ren_ready SHALL be 1.
REQ-016 Reset SHALL take effect mid-operation, discarding any in-flight group.

Structure
REQ-017 Package rename_pkg SHALL hold the defaults, PW/AW and the preg_t/areg_t typedefs.
REQ-018 Sub-module free_list_alloc SHALL hold the free bit vector, REN_W-way lowest-free select, retire free and flush rebuild.

Verification
REQ-019 Reset, then rename {rd=1 (x1), rd=2 (x2)} -> prd P32,P33; old_prd 1,2; free_count 30.
REQ-020 Group slot0 rd=x5, slot1 rs1=x5, rd=x5 -> slot1 prs1=P32, old_prd=P32, RAT[5]=P33.
REQ-021 Allocate 32 tags with no retire -> ren_ready=0; one retire of P5 -> ren_ready=0 (count 1 < 2); second retire -> ren_ready=1.
REQ-022 Rename x3->P32, retire nothing, flush -> RAT[3]=3, free_count=32, P32 reallocated first.
REQ-023 Retire (x4, P40, old P4) in the same cycle as flush -> RAT[4]=P40, P4 free, P40 not free.
REQ-024 rd=0 and rs=0 slots -> prd 0, prs 0, no count change.
